// File: rtl/output_drain.sv
// output_drain
//   Reads a programmed range of output-memory rows and serialises each row
//   into MM_SIZE-bit words on a valid/ready stream. A start pulse (taken only
//   while idle) captures base_addr/length. busy covers the whole drain, and
//   done pulses once at the end.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   start              one-cycle drain request (ignored unless idle)
//   base_addr, length  first row and row count (0..2^OUTPUT_MEM_DEPTH)
//   busy, done         status: high while not idle / end-of-drain pulse
//   mem_rd_en/addr     output-memory read port (data returns one cycle later)
//   mem_rd_data        read data, NU_COUNT lanes of Q_SIZE bits, lane0 in LSBs
//   m_valid/ready      stream handshake
//   m_data, m_last     stream word and end-of-drain marker
module output_drain #(
  parameter int NU_COUNT         = 4,
  parameter int Q_SIZE           = 16,
  parameter int OUTPUT_MEM_DEPTH = 6,
  parameter int MM_SIZE          = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [OUTPUT_MEM_DEPTH-1:0]   base_addr,
  input  logic [OUTPUT_MEM_DEPTH:0]     length,
  output logic                          busy,
  output logic                          done,
  output logic                          mem_rd_en,
  output logic [OUTPUT_MEM_DEPTH-1:0]   mem_rd_addr,
  input  logic [NU_COUNT*Q_SIZE-1:0]    mem_rd_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [MM_SIZE-1:0]            m_data,
  output logic                          m_last
);

  localparam int ROW_W = NU_COUNT * Q_SIZE;
  localparam int WORDS = ROW_W / MM_SIZE;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W = OUTPUT_MEM_DEPTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [2:0] {IDLE, READ, LOAD, SEND, DONE} state_t;

  state_t                      state;
  logic [OUTPUT_MEM_DEPTH-1:0] base_q;
  logic [CNT_W-1:0]            len_q;
  logic [CNT_W-1:0]            row_cnt;
  logic [CNT_W-1:0]            row_nxt;
  logic [IDX_W-1:0]            word_idx;
  logic [IDX_W-1:0]            idx_nxt;
  logic [ROW_W-1:0]            row_reg;
  logic                        final_row;

  // Word selector over the latched row; word 0 holds the lowest lanes.
  function automatic logic [MM_SIZE-1:0] word_sel(input logic [ROW_W-1:0] row,
                                                  input logic [IDX_W-1:0] idx);
    logic [MM_SIZE-1:0] w;
    w = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx == IDX_W'(i)) w = row[i*MM_SIZE +: MM_SIZE];
    end
    return w;
  endfunction

  // row_cnt is one bit wider than the address so a 64-row drain terminates.
  assign row_nxt   = row_cnt + 1'b1;
  assign idx_nxt   = word_idx + 1'b1;
  assign final_row = (row_nxt == len_q);

  // Row register: pure data, captured at the end of LOAD.
  always_ff @(posedge clk) begin
    if (state == LOAD) row_reg <= mem_rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_data      <= '0;
      base_q      <= '0;
      len_q       <= '0;
      row_cnt     <= '0;
      word_idx    <= '0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (length != '0) begin
              base_q      <= base_addr;
              len_q       <= length;
              row_cnt     <= '0;
              word_idx    <= '0;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= base_addr;
              state       <= READ;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        READ: state <= LOAD;
        LOAD: begin
          // Memory data is valid this cycle; word 0 comes straight from it.
          m_valid  <= 1'b1;
          m_data   <= mem_rd_data[MM_SIZE-1:0];
          m_last   <= (LAST_IDX == '0) && final_row;
          word_idx <= '0;
          state    <= SEND;
        end
        SEND: begin
          if (m_ready) begin
            if (word_idx != LAST_IDX) begin
              word_idx <= idx_nxt;
              m_data   <= word_sel(row_reg, idx_nxt);
              m_last   <= (idx_nxt == LAST_IDX) && final_row;
            end else begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              if (final_row) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                row_cnt     <= row_nxt;
                mem_rd_en   <= 1'b1;
                // Address add truncates, so the range wraps past the top row.
                mem_rd_addr <= base_q + row_nxt[OUTPUT_MEM_DEPTH-1:0];
                state       <= READ;
              end
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_drain.sv
module tb_output_drain;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  base_addr;
  logic [6:0]  length;
  logic        busy;
  logic        done;
  logic        mem_rd_en;
  logic [5:0]  mem_rd_addr;
  logic [63:0] mem_rd_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  output_drain #(
    .NU_COUNT(4), .Q_SIZE(16), .OUTPUT_MEM_DEPTH(6), .MM_SIZE(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int s_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Row r of the output memory: lanes {0r03,0r02,0r01,0r00}, lane0 in LSBs.
  function automatic logic [63:0] row_val(input logic [5:0] r);
    return {2'b00, r, 8'h03, 2'b00, r, 8'h02, 2'b00, r, 8'h01, 2'b00, r, 8'h00};
  endfunction

  // One-cycle read latency memory model.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= row_val(mem_rd_addr);
  end

  // m_ready source: mode 0 = always ready, 1 = pattern 1,0,0,1, 2 = never ready.
  int ready_mode = 0;
  int pat_k = 0;
  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: m_ready = 1'b1;
        1: begin m_ready = pat[pat_k % 4]; pat_k++; end
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor, sampling mid-cycle.
  logic [5:0]  rd_q[$];
  logic [31:0] beat_q[$];
  logic        last_q[$];
  int done_cnt, done_rel, busy_cnt, valid_cnt, stall_err;
  int first_rd_rel, first_beat_rel;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic        prev_last;

  initial begin
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_rd_en) begin
        if (rd_q.size() == 0) first_rd_rel = cyc - s_cyc + 1;
        rd_q.push_back(mem_rd_addr);
      end
      if (m_valid) valid_cnt++;
      if (m_valid && m_ready) begin
        if (beat_q.size() == 0) first_beat_rel = cyc - s_cyc + 1;
        beat_q.push_back(m_data);
        last_q.push_back(m_last);
      end
      if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
        stall_err++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (done) begin done_cnt++; done_rel = cyc - s_cyc + 1; end
      if (busy) busy_cnt++;
    end
  end

  task automatic clear_mon();
    rd_q.delete(); beat_q.delete(); last_q.delete();
    done_cnt = 0; done_rel = -1; busy_cnt = 0; valid_cnt = 0; stall_err = 0;
    first_rd_rel = -1; first_beat_rel = -1; prev_stall = 1'b0; pat_k = 0;
  endtask

  task automatic do_start(input logic [5:0] b, input logic [6:0] l);
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = l;
    @(posedge clk); #1;
    start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic wait_done(input int max, input string name);
    int n = 0;
    while (done_cnt == 0 && n < max) begin @(posedge clk); n++; end
    total_cnt++;
    if (done_cnt == 0) $display("FAIL %s_timeout: no done within %0d cycles", name, max);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (mem_rd_en !== 1'b0) $display("FAIL rst_rd_en: got %b want 0", mem_rd_en); else pass_cnt++;
    total_cnt++; if (mem_rd_addr !== 6'd0) $display("FAIL rst_rd_addr: got %0d want 0", mem_rd_addr); else pass_cnt++;
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", m_valid); else pass_cnt++;
    total_cnt++; if (m_last !== 1'b0) $display("FAIL rst_last: got %b want 0", m_last); else pass_cnt++;
    total_cnt++; if (m_data !== 32'h0) $display("FAIL rst_data: got %h want 0", m_data); else pass_cnt++;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  // Shared expectation for the base=5,length=3 transfer.
  logic [31:0] exp5 [6] = '{32'h0501_0500, 32'h0503_0502, 32'h0601_0600,
                            32'h0603_0602, 32'h0701_0700, 32'h0703_0702};

  task automatic test_basic();
    ready_mode = 0;
    do_start(6'd5, 7'd3);
    wait_done(40, "basic");
    total_cnt++; if (rd_q.size() != 3) $display("FAIL basic_reads: got %0d want 3", rd_q.size()); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (rd_q.size() > i && rd_q[i] !== 6'(5 + i)) $display("FAIL basic_addr%0d: got %0d want %0d", i, rd_q[i], 5 + i);
      else if (rd_q.size() <= i) $display("FAIL basic_addr%0d: missing want %0d", i, 5 + i);
      else pass_cnt++;
    end
    total_cnt++; if (beat_q.size() != 6) $display("FAIL basic_beats: got %0d want 6", beat_q.size()); else pass_cnt++;
    for (int i = 0; i < 6 && i < beat_q.size(); i++) begin
      total_cnt++;
      if (beat_q[i] !== exp5[i]) $display("FAIL basic_data%0d: got %h want %h", i, beat_q[i], exp5[i]); else pass_cnt++;
      total_cnt++;
      if (last_q[i] !== (i == 5)) $display("FAIL basic_last%0d: got %b want %b", i, last_q[i], (i == 5)); else pass_cnt++;
    end
    total_cnt++; if (first_rd_rel != 1) $display("FAIL basic_rd_lat: got %0d want 1", first_rd_rel); else pass_cnt++;
    total_cnt++; if (first_beat_rel != 3) $display("FAIL basic_beat_lat: got %0d want 3", first_beat_rel); else pass_cnt++;
    total_cnt++; if (done_cnt != 1) $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); else pass_cnt++;
    total_cnt++; if (done_rel != 13) $display("FAIL basic_done_cyc: got %0d want 13", done_rel); else pass_cnt++;
    total_cnt++; if (busy_cnt != 13) $display("FAIL basic_busy_cycles: got %0d want 13", busy_cnt); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    ready_mode = 1;
    do_start(6'd5, 7'd3);
    wait_done(80, "bp");
    ready_mode = 0;
    total_cnt++; if (beat_q.size() != 6) $display("FAIL bp_beats: got %0d want 6", beat_q.size()); else pass_cnt++;
    for (int i = 0; i < 6 && i < beat_q.size(); i++) begin
      total_cnt++;
      if (beat_q[i] !== exp5[i] || last_q[i] !== (i == 5))
        $display("FAIL bp_beat%0d: got %h/%b want %h/%b", i, beat_q[i], last_q[i], exp5[i], (i == 5));
      else pass_cnt++;
    end
    total_cnt++; if (stall_err != 0) $display("FAIL bp_stable: got %0d unstable stall cycles want 0", stall_err); else pass_cnt++;
    total_cnt++; if (rd_q.size() != 3) $display("FAIL bp_reads: got %0d want 3", rd_q.size()); else pass_cnt++;
    total_cnt++; if (done_cnt != 1) $display("FAIL bp_done: got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [5:0] ea [3] = '{6'd62, 6'd63, 6'd0};
    ready_mode = 0;
    do_start(6'd62, 7'd3);
    wait_done(40, "wrap");
    total_cnt++; if (rd_q.size() != 3) $display("FAIL wrap_reads: got %0d want 3", rd_q.size()); else pass_cnt++;
    for (int i = 0; i < 3 && i < rd_q.size(); i++) begin
      total_cnt++;
      if (rd_q[i] !== ea[i]) $display("FAIL wrap_addr%0d: got %0d want %0d", i, rd_q[i], ea[i]); else pass_cnt++;
    end
    total_cnt++; if (beat_q.size() != 6) $display("FAIL wrap_beats: got %0d want 6", beat_q.size()); else pass_cnt++;
    if (beat_q.size() == 6) begin
      total_cnt++; if (beat_q[0] !== 32'h3E01_3E00) $display("FAIL wrap_beat0: got %h want 3e013e00", beat_q[0]); else pass_cnt++;
      total_cnt++; if (beat_q[5] !== 32'h0003_0002) $display("FAIL wrap_beat5: got %h want 00030002", beat_q[5]); else pass_cnt++;
    end
    total_cnt++; if (done_cnt != 1) $display("FAIL wrap_done: got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_zero_len();
    ready_mode = 0;
    do_start(6'd9, 7'd0);
    wait_done(10, "zero");
    total_cnt++; if (done_rel != 1) $display("FAIL zero_done_cyc: got %0d want 1", done_rel); else pass_cnt++;
    total_cnt++; if (rd_q.size() != 0) $display("FAIL zero_reads: got %0d want 0", rd_q.size()); else pass_cnt++;
    total_cnt++; if (valid_cnt != 0) $display("FAIL zero_valid: got %0d want 0", valid_cnt); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL zero_busy_end: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_full();
    int nlast = 0;
    ready_mode = 0;
    do_start(6'd0, 7'd64);
    wait_done(400, "full");
    total_cnt++; if (beat_q.size() != 128) $display("FAIL full_beats: got %0d want 128", beat_q.size()); else pass_cnt++;
    total_cnt++; if (rd_q.size() != 64) $display("FAIL full_reads: got %0d want 64", rd_q.size()); else pass_cnt++;
    if (rd_q.size() == 64) begin
      total_cnt++; if (rd_q[63] !== 6'd63) $display("FAIL full_last_addr: got %0d want 63", rd_q[63]); else pass_cnt++;
    end
    if (beat_q.size() == 128) begin
      total_cnt++; if (last_q[127] !== 1'b1) $display("FAIL full_last_flag: got %b want 1", last_q[127]); else pass_cnt++;
      total_cnt++; if (beat_q[127] !== 32'h3F03_3F02) $display("FAIL full_beat127: got %h want 3f033f02", beat_q[127]); else pass_cnt++;
    end
    foreach (last_q[i]) if (last_q[i]) nlast++;
    total_cnt++; if (nlast != 1) $display("FAIL full_last_count: got %0d want 1", nlast); else pass_cnt++;
  endtask

  task automatic test_restart_ignored();
    ready_mode = 0;
    do_start(6'd10, 7'd2);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 6'd20; length = 7'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40, "restart");
    total_cnt++; if (rd_q.size() != 2) $display("FAIL restart_reads: got %0d want 2", rd_q.size()); else pass_cnt++;
    if (rd_q.size() == 2) begin
      total_cnt++;
      if (rd_q[0] !== 6'd10 || rd_q[1] !== 6'd11) $display("FAIL restart_addrs: got %0d,%0d want 10,11", rd_q[0], rd_q[1]);
      else pass_cnt++;
    end
    total_cnt++; if (beat_q.size() != 4) $display("FAIL restart_beats: got %0d want 4", beat_q.size()); else pass_cnt++;
    total_cnt++; if (done_cnt != 1) $display("FAIL restart_done: got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    ready_mode = 2;
    do_start(6'd30, 7'd2);
    while (!m_valid && n < 10) begin @(posedge clk); #1; n++; end
    total_cnt++; if (m_valid !== 1'b1) $display("FAIL rmid_valid_before: got %b want 1", m_valid); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", m_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (mem_rd_en !== 1'b0) $display("FAIL rmid_rd_en: got %b want 0", mem_rd_en); else pass_cnt++;
    total_cnt++; if (m_data !== 32'h0) $display("FAIL rmid_data: got %h want 0", m_data); else pass_cnt++;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    total_cnt++; if (done_cnt != 0) $display("FAIL rmid_no_done: got %0d want 0", done_cnt); else pass_cnt++;
    ready_mode = 0;
    do_start(6'd40, 7'd1);
    wait_done(20, "rmid_fresh");
    total_cnt++;
    if (rd_q.size() != 1 || rd_q[0] !== 6'd40) $display("FAIL rmid_fresh_addr: got %0d reads want one read at 40", rd_q.size());
    else pass_cnt++;
    total_cnt++; if (beat_q.size() != 2) $display("FAIL rmid_fresh_beats: got %0d want 2", beat_q.size()); else pass_cnt++;
    if (beat_q.size() == 2) begin
      total_cnt++;
      if (beat_q[0] !== 32'h2801_2800 || beat_q[1] !== 32'h2803_2802)
        $display("FAIL rmid_fresh_data: got %h,%h want 28012800,28032802", beat_q[0], beat_q[1]);
      else pass_cnt++;
      total_cnt++; if (last_q[1] !== 1'b1 || last_q[0] !== 1'b0) $display("FAIL rmid_fresh_last: got %b%b want 10", last_q[1], last_q[0]); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_full();
    test_restart_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
